// File: rtl/driver_rx_model.sv
// LED-driver serial receiver (one lane): LAT edge-count decode, 48-bit shift register, FC/GS banks; optional SOUT echo under DRIVER_RX_SOUT_EN.
// Latency: all outputs registered, updates and pulses appear 1 clk_33 after LAT is first sampled low.
// Backpressure: none, every sclk_en and LAT fall is consumed in the cycle it is sampled.
module driver_rx_model #(
    parameter int SR_WIDTH = 48,
    parameter int GS_WORDS = 9
) (
    input  logic                         clk_33,
    input  logic                         nrst,
    input  logic                         sclk_en,
    input  logic                         lat,
    input  logic                         sin,
    output logic [SR_WIDTH-1:0]          conf_data,
    output logic                         conf_valid,
    output logic [GS_WORDS*SR_WIDTH-1:0] gs_data,
    output logic                         gs_valid,
    output logic                         cmd_strobe,
    output logic [2:0]                   cmd_code,
    output logic                         err_unknown,
    output logic                         err_overflow,
    output logic                         err_fc_locked,
    output logic                         sout
);
    localparam int PW = $clog2(GS_WORDS);
    localparam logic [PW-1:0] PTR_LAST = PW'(GS_WORDS - 1);

    typedef logic [GS_WORDS-1:0][SR_WIDTH-1:0] bank_t;

    logic [SR_WIDTH-1:0] sr_q, sr_d;
    logic [4:0]          lat_cnt_q, lat_cnt_d;
    logic                lat_q;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic                fc_en_q, fc_en_d;
    bank_t               bank1_q, bank1_d;
    bank_t               gs_q, gs_d;
    logic [SR_WIDTH-1:0] conf_q, conf_d;
    logic [2:0]          code_q, code_d;
    logic                strobe_q, strobe_d;
    logic                conf_vld_q, conf_vld_d;
    logic                gs_vld_q, gs_vld_d;
    logic                e_unk_q, e_unk_d;
    logic                e_ovf_q, e_ovf_d;
    logic                e_lock_q, e_lock_d;
    logic                lat_fall;

    assign lat_fall = lat_q & ~lat;

    always_comb begin
        sr_d       = sclk_en ? {sr_q[SR_WIDTH-2:0], sin} : sr_q;
        lat_cnt_d  = lat_cnt_q;
        ptr_d      = ptr_q;
        fc_en_d    = fc_en_q;
        bank1_d    = bank1_q;
        gs_d       = gs_q;
        conf_d     = conf_q;
        code_d     = code_q;
        strobe_d   = 1'b0;
        conf_vld_d = 1'b0;
        gs_vld_d   = 1'b0;
        e_unk_d    = 1'b0;
        e_ovf_d    = 1'b0;
        e_lock_d   = 1'b0;

        // A fall restarts counting; lat cannot be high in the fall cycle so no edge is lost.
        if (lat_fall) begin
            lat_cnt_d = 5'd0;
        end else if (lat && sclk_en && lat_cnt_q != 5'd31) begin
            lat_cnt_d = lat_cnt_q + 5'd1;
        end

        if (lat_fall) begin
            strobe_d = 1'b1;
            case (lat_cnt_q)
                5'd1: begin
                    code_d = 3'd1;
                    for (int k = 0; k < GS_WORDS; k++) begin
                        if (ptr_q == PW'(k)) bank1_d[k] = sr_q;
                    end
                    if (ptr_q < PTR_LAST) ptr_d = ptr_q + 1'b1;
                    else                  e_ovf_d = 1'b1;
                end
                5'd3: begin
                    code_d = 3'd2;
                    for (int k = 0; k < GS_WORDS; k++) begin
                        if (ptr_q == PW'(k)) bank1_d[k] = sr_q;
                    end
                    gs_d     = bank1_d;
                    ptr_d    = '0;
                    gs_vld_d = 1'b1;
                end
                5'd5: begin
                    code_d = 3'd3;
                    if (fc_en_q) begin
                        conf_d     = sr_q;
                        conf_vld_d = 1'b1;
                        fc_en_d    = 1'b0;
                    end else begin
                        e_lock_d = 1'b1;
                    end
                end
                5'd15: begin
                    code_d  = 3'd4;
                    fc_en_d = 1'b1;
                end
                default: begin
                    code_d  = 3'd0;
                    e_unk_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            sr_q       <= '0;
            lat_cnt_q  <= '0;
            lat_q      <= 1'b0;
            ptr_q      <= '0;
            fc_en_q    <= 1'b0;
            bank1_q    <= '0;
            gs_q       <= '0;
            conf_q     <= '0;
            code_q     <= '0;
            strobe_q   <= 1'b0;
            conf_vld_q <= 1'b0;
            gs_vld_q   <= 1'b0;
            e_unk_q    <= 1'b0;
            e_ovf_q    <= 1'b0;
            e_lock_q   <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            lat_cnt_q  <= lat_cnt_d;
            lat_q      <= lat;
            ptr_q      <= ptr_d;
            fc_en_q    <= fc_en_d;
            bank1_q    <= bank1_d;
            gs_q       <= gs_d;
            conf_q     <= conf_d;
            code_q     <= code_d;
            strobe_q   <= strobe_d;
            conf_vld_q <= conf_vld_d;
            gs_vld_q   <= gs_vld_d;
            e_unk_q    <= e_unk_d;
            e_ovf_q    <= e_ovf_d;
            e_lock_q   <= e_lock_d;
        end
    end

`ifdef DRIVER_RX_SOUT_EN
    logic sout_q;

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            sout_q <= 1'b0;
        end else if (sclk_en) begin
            sout_q <= sr_d[SR_WIDTH-1];
        end
    end

    assign sout = sout_q;
`else
    assign sout = 1'b0;
`endif

    assign conf_data     = conf_q;
    assign conf_valid    = conf_vld_q;
    assign gs_data       = gs_q;
    assign gs_valid      = gs_vld_q;
    assign cmd_strobe    = strobe_q;
    assign cmd_code      = code_q;
    assign err_unknown   = e_unk_q;
    assign err_overflow  = e_ovf_q;
    assign err_fc_locked = e_lock_q;
endmodule

// File: tb/tb_driver_rx_model.sv
// Directed bench for driver_rx_model: table of LAT commands plus hand sequences for GS frames, overflow, back-to-back and reset.
module tb_driver_rx_model;
    localparam int W = 48;
    localparam int N = 9;

    logic             clk_33 = 1'b0;
    logic             nrst;
    logic             sclk_en, lat, sin;
    logic [W-1:0]     conf_data;
    logic             conf_valid, gs_valid, cmd_strobe;
    logic [N*W-1:0]   gs_data;
    logic [2:0]       cmd_code;
    logic             err_unknown, err_overflow, err_fc_locked, sout;

    int n_checks = 0;
    int n_fail   = 0;

    driver_rx_model #(.SR_WIDTH(W), .GS_WORDS(N)) dut (
        .clk_33(clk_33), .nrst(nrst), .sclk_en(sclk_en), .lat(lat), .sin(sin),
        .conf_data(conf_data), .conf_valid(conf_valid), .gs_data(gs_data),
        .gs_valid(gs_valid), .cmd_strobe(cmd_strobe), .cmd_code(cmd_code),
        .err_unknown(err_unknown), .err_overflow(err_overflow),
        .err_fc_locked(err_fc_locked), .sout(sout)
    );

    always #15 clk_33 = ~clk_33;

    typedef struct {
        logic [W-1:0] word;
        int           edges;
        logic [2:0]   code;
        logic [4:0]   flags;   // {conf_valid, gs_valid, err_unknown, err_overflow, err_fc_locked}
        logic [W-1:0] conf;
    } vec_t;

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_33);
        #1;
    endtask

    task automatic shift_bit(input logic b, input logic l);
        sin = b; lat = l; sclk_en = 1'b1;
        tick();
        sclk_en = 1'b0; sin = 1'b0;
    endtask

    // n edges under LAT high (bits[n-1:0], MSB first), then the LAT-fall cycle.
    task automatic cmd_edges(input logic [W-1:0] bits, input int n, input logic fsclk, input logic fsin);
        for (int i = n - 1; i >= 0; i--) shift_bit(bits[i], 1'b1);
        lat = 1'b0; sclk_en = fsclk; sin = fsin;
        tick();
        sclk_en = 1'b0; sin = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] word, input int n, input logic fsclk, input logic fsin);
        for (int i = W - 1; i >= n; i--) shift_bit(word[i], 1'b0);
        cmd_edges(word, n, fsclk, fsin);
    endtask

    task automatic chk_idle(input string name);
        chk(name, {cmd_strobe, conf_valid, gs_valid, err_unknown, err_overflow, err_fc_locked}, '0);
    endtask

    vec_t         vecs[8];
    logic [W-1:0] wb2b, exp_conf;
    logic [4:0]   b2b_bits;
    logic [N*W-1:0] exp_gs;
    int           seen;

    initial begin
        vecs[0] = '{48'h0,            5,  3'd3, 5'b00001, 48'h0};
        vecs[1] = '{48'h0,            15, 3'd4, 5'b00000, 48'h0};
        vecs[2] = '{48'hA5A5_0000_FFFF, 5,  3'd3, 5'b10000, 48'hA5A5_0000_FFFF};
        vecs[3] = '{48'h1234_5678_9ABC, 5,  3'd3, 5'b00001, 48'hA5A5_0000_FFFF};
        vecs[4] = '{48'h0,            7,  3'd0, 5'b00100, 48'hA5A5_0000_FFFF};
        vecs[5] = '{48'h0,            15, 3'd4, 5'b00000, 48'hA5A5_0000_FFFF};
        vecs[6] = '{48'h0,            15, 3'd4, 5'b00000, 48'hA5A5_0000_FFFF};
        vecs[7] = '{48'h0000_0000_0042, 5,  3'd3, 5'b10000, 48'h0000_0000_0042};

        nrst = 1'b0; lat = 1'b0; sin = 1'b0; sclk_en = 1'b0;
        #40;
        chk("reset_conf", conf_data, '0);
        chk("reset_gs", gs_data, '0);
        chk("reset_pulses", {cmd_strobe, cmd_code, conf_valid, gs_valid, err_unknown,
                             err_overflow, err_fc_locked, sout}, '0);
        @(posedge clk_33); #1;
        nrst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            send_word(vecs[i].word, vecs[i].edges, 1'b0, 1'b0);
            chk($sformatf("vec%0d_strobe", i), cmd_strobe, 1'b1);
            chk($sformatf("vec%0d_code", i), cmd_code, vecs[i].code);
            chk($sformatf("vec%0d_flags", i),
                {conf_valid, gs_valid, err_unknown, err_overflow, err_fc_locked}, vecs[i].flags);
            chk($sformatf("vec%0d_conf", i), conf_data, vecs[i].conf);
            tick();
            chk_idle($sformatf("vec%0d_width", i));
        end

        // Back-to-back FCWRTEN then WRTFC, with sclk_en in both LAT-fall cycles.
        wb2b = 48'h0123_4567_89AB;
        b2b_bits = 5'b10110;
        send_word(wb2b, 15, 1'b1, 1'b1);
        chk("b2b_fcen_code", {cmd_strobe, cmd_code}, {1'b1, 3'd4});
        cmd_edges({43'h0, b2b_bits}, 5, 1'b1, 1'b0);
        exp_conf = {wb2b[41:0], 1'b1, b2b_bits};
        chk("b2b_wrtfc_code", {cmd_strobe, cmd_code, conf_valid}, {1'b1, 3'd3, 1'b1});
        chk("b2b_conf", conf_data, exp_conf);
        tick();

        // Full GS frame: 8 WRTGS then LATGS.
        exp_gs = '0;
        for (int k = 0; k < N; k++) exp_gs[k*W +: W] = W'(k + 1);
        for (int k = 0; k < N - 1; k++) begin
            send_word(W'(k + 1), 1, 1'b0, 1'b0);
            chk($sformatf("gs_wr%0d", k), {cmd_strobe, cmd_code, gs_valid, err_overflow},
                {1'b1, 3'd1, 1'b0, 1'b0});
            tick();
        end
        send_word(W'(N), 3, 1'b0, 1'b0);
        chk("gs_latgs", {cmd_strobe, cmd_code, gs_valid}, {1'b1, 3'd2, 1'b1});
        chk("gs_data", gs_data, exp_gs);
        chk("gs_ptr", dut.ptr_q, '0);
        tick();
        chk_idle("gs_width");

        // Ten WRTGS: overflow on the 9th and 10th, last word held in slot 8.
        for (int i = 1; i <= 10; i++) begin
            send_word(W'(48'h100 + i), 1, 1'b0, 1'b0);
            chk($sformatf("ovf_wr%0d", i), {cmd_strobe, cmd_code, err_overflow},
                {1'b1, 3'd1, (i >= 9) ? 1'b1 : 1'b0});
            tick();
        end
        chk("ovf_bank8", dut.bank1_q[8], 48'h10A);
        chk("ovf_gs_unchanged", gs_data, exp_gs);

        // SOUT echo of the MSB.
        for (int i = W - 1; i >= 0; i--) shift_bit((i == W - 1) ? 1'b1 : 1'b0, 1'b0);
`ifdef DRIVER_RX_SOUT_EN
        chk("sout", sout, 1'b1);
`else
        chk("sout", sout, 1'b0);
`endif
        tick();

        // LAT held high never decodes, even past count saturation.
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            shift_bit(1'b1, 1'b1);
            if (cmd_strobe) seen++;
        end
        chk("held_high_no_decode", seen, 0);

        // Reset while LAT is high mid-command, LAT drops before the first post-release edge.
        nrst = 1'b0;
        #1;
        chk("midreset_outputs", {conf_data, cmd_strobe, cmd_code, conf_valid, gs_valid,
                                 err_unknown, err_overflow, err_fc_locked, sout}, '0);
        chk("midreset_gs", gs_data, '0);
        tick();
        tick();
        nrst = 1'b1; lat = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cmd_strobe) seen++;
        end
        chk("postreset_no_decode", seen, 0);

        // fc_en was cleared by reset.
        send_word(48'hFFFF_FFFF_FFFF, 5, 1'b0, 1'b0);
        chk("postreset_locked", {cmd_strobe, cmd_code, conf_valid, err_fc_locked},
            {1'b1, 3'd3, 1'b0, 1'b1});
        chk("postreset_conf", conf_data, '0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/driver_rx_model.md
# driver_rx_model

Synthesizable receiver for the LED-driver serial bus (SCLK/LAT/SIN), one driver lane. It decodes LAT commands by counting SCLK rising edges while LAT is high, shifts SIN into a 48-bit common shift register, and latches that register into the function-control or GS banks. It instantiates once per lane behind the driver main controller for on-FPGA loopback checking, and also serves as the bench scoreboard model.

## Interface
Parameters:
- SR_WIDTH, 48, common shift register width in bits; also the function-control register width.
- GS_WORDS, 9, number of SR_WIDTH words per GS frame (8 WRTGS + 1 LATGS).

Ports:
- clk_33  in  1  system clock; all inputs are sampled on its rising edge.
- nrst  in  1  asynchronous, active-low reset.
- sclk_en  in  1  high = one driver SCLK rising edge occurs this clk_33 cycle (the gating qualifier of driver_sclk).
- lat  in  1  driver LAT.
- sin  in  1  driver SIN for this lane.
- conf_data  out  SR_WIDTH  function-control register.
- conf_valid  out  1  one-cycle pulse when conf_data is updated.
- gs_data  out  GS_WORDS*SR_WIDTH  GS bank 2 (displayed frame); word k occupies bits [k*SR_WIDTH +: SR_WIDTH].
- gs_valid  out  1  one-cycle pulse when bank 2 is updated.
- cmd_strobe  out  1  one-cycle pulse per decoded LAT command.
- cmd_code  out  3  0 unknown, 1 WRTGS, 2 LATGS, 3 WRTFC, 4 FCWRTEN; valid with cmd_strobe.
- err_unknown  out  1  pulse: edge count not in {1,3,5,15}.
- err_overflow  out  1  pulse: WRTGS with the bank-1 pointer already at GS_WORDS-1.
- err_fc_locked  out  1  pulse: WRTFC without a prior FCWRTEN.
- sout  out  1  SOUT echo (see Configuration).

## Operation
- Shift: on each cycle with sclk_en=1, sr <= {sr[SR_WIDTH-2:0], sin}. Shifting happens regardless of lat. The MSB is shifted in first.
- Edge count: lat_cnt (5 bits) increments, saturating at 31, on cycles with lat=1 and sclk_en=1. It clears in the cycle after a command is decoded.
- Decode: a falling edge is detected when lat_q=1 and lat=0, where lat_q is lat registered. The command uses the sr register value and lat_cnt before that cycle's updates.
  - 1 (WRTGS): bank1[ptr] <= sr. If ptr < GS_WORDS-1, ptr++. Otherwise the bank-1 write still occurs, ptr holds, and err_overflow is raised.
  - 3 (LATGS): bank1[ptr] <= sr. Bank 2 <= bank 1 including this word. ptr <= 0. gs_valid is raised.
  - 5 (WRTFC): if fc_en=1, conf_data <= sr, conf_valid is raised, and fc_en <= 0. Otherwise nothing is written and err_fc_locked is raised.
  - 15 (FCWRTEN): fc_en <= 1.
  - Any other count: no register changes and err_unknown is raised.
- Each decode raises cmd_strobe with the matching cmd_code.
- Reset values: sr, bank1, gs_data, conf_data, lat_cnt, ptr and fc_en are 0; lat_q is 0. All pulse outputs and sout are 0.
- Reset mid-command: all state clears. A LAT falling edge seen after reset release with lat_q=0 is not detected.

## Timing
- Latency: outputs are registered. The pulses and data updates appear on the clk_33 edge after the cycle in which lat is first sampled low, i.e. 1 cycle after the LAT fall.
- A sclk_en in the LAT-fall cycle shifts sr but is not counted and is not part of the latched word.
- Back-to-back commands are allowed. lat may return high on the cycle immediately after the fall, and counting restarts from 0 in that cycle.
- Pulses are exactly one cycle wide. At most one command is decoded per cycle.
- A lat held high with no falling edge never decodes.

## Configuration
- DRIVER_RX_SOUT_EN defined: sout = sr[SR_WIDTH-1], registered, updated on each sclk_en cycle. This models SOUT daisy-chain output for LOD readback checks.
- Not defined: sout is constant 0 and no extra flop is built.

## Test plan
- FCWRTEN (15 edges), then 48 bits 0xA5A5_0000_FFFF with WRTFC over the last 5 edges -> conf_data=0xA5A5_0000_FFFF, conf_valid pulses once, cmd_code sequence 4 then 3.
- WRTFC (5 edges) without a prior FCWRTEN -> conf_data unchanged, err_fc_locked=1 for one cycle, cmd_code=3.
- 8 words k=0..7 of value k+1, each closed by WRTGS, then word 9 with LATGS (3 edges) -> gs_data words 0..8 = 1..9, gs_valid pulses once, ptr returns to 0.
- 10 WRTGS in a row -> err_overflow pulses on the 9th and 10th, and bank1 word 8 holds the 10th word.
- LAT high for 7 edges -> err_unknown pulses and cmd_code=0. nrst asserted while LAT is high mid-command -> all outputs 0, and no decode after release.
- With DRIVER_RX_SOUT_EN defined, shift in 0x8000_0000_0000 -> sout=1 on the cycle after the 48th shift. Without the macro, sout stays 0.
